// File: rtl/io_input_router_pkg.sv
// io_input_router_pkg: shared types and constants for the UART input router.
//   parse_state_e  : header parser states
//   fifo_entry_t   : payload FIFO entry {data, chan, last, err}
//   HDR_*          : header byte field positions
package io_input_router_pkg;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } parse_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] chan;
        logic       last;
        logic       err;
    } fifo_entry_t;

    localparam int ENTRY_W     = $bits(fifo_entry_t);

    // Header byte: [7:6] channel, [5:0] payload length minus one
    localparam int HDR_CHAN_HI = 7;
    localparam int HDR_CHAN_LO = 6;
    localparam int HDR_LEN_HI  = 5;
    localparam int HDR_LEN_LO  = 0;

endpackage

// File: rtl/io_input_router_fifo.sv
// io_input_router_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write one entry (ignored when full)
//   pop        : remove head entry (ignored when empty)
//   rdata      : head entry, valid whenever count != 0
//   count      : current occupancy, 0..DEPTH
module io_input_router_fifo #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_input_router.sv
// io_input_router: routes framed UART bytes to up to four consumers.
//   clk, rst_n             : clock, async active-low reset
//   io_input_trigger/value : received byte strobe and data
//   out_valid[CHANNELS]    : one-hot, head byte available for that channel
//   out_ready[CHANNELS]    : consumer accepts
//   out_data/last/err      : head byte, end-of-frame, timeout terminator
//   overflow               : sticky, a frame was discarded (or timed out)
//   drop_count             : discarded bytes incl. headers, saturating
//   clear_overflow         : clears overflow and drop_count
// Optional feature macro: IO_INPUT_ROUTER_TIMEOUT_EN enables the inter-byte
// timeout, which terminates a stalled frame with an err entry.
module io_input_router
    import io_input_router_pkg::*;
#(
    parameter  int CH_BITS        = 2,
    parameter  int FIFO_DEPTH     = 64,
    parameter  int TIMEOUT_CYCLES = 100000,
    localparam int CHANNELS       = 1 << CH_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                io_input_trigger,
    input  logic [7:0]          io_input_value,
    output logic [CHANNELS-1:0] out_valid,
    input  logic [CHANNELS-1:0] out_ready,
    output logic [7:0]          out_data,
    output logic                out_last,
    output logic                out_err,
    output logic                overflow,
    output logic [7:0]          drop_count,
    input  logic                clear_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    parse_state_e      state;
    logic [1:0]        chan;
    logic [6:0]        remaining;

    fifo_entry_t       wr_entry;
    fifo_entry_t       head;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic              has_head;

    logic [6:0]        hdr_len;
    logic [CW-1:0]     free_slots;
    logic              admit;
    logic              drop_evt;
    logic              timeout;
    logic [7:0]        dc_base;

    // Admission uses occupancy before this cycle's pop, so it is conservative.
    assign hdr_len    = {1'b0, io_input_value[HDR_LEN_HI:HDR_LEN_LO]} + 7'd1;
    assign free_slots = DEPTH_C - count;
    assign admit      = free_slots >= CW'(hdr_len);

    assign drop_evt = io_input_trigger &&
                      (((state == HEADER) && !admit) || (state == DISCARD));

`ifdef IO_INPUT_ROUTER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_cnt;

    // A trigger on the expiry edge wins: the frame simply continues.
    assign timeout = (state != HEADER) && !io_input_trigger &&
                     (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (state == HEADER || io_input_trigger || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + IW'(1);
    end

    assign out_err = has_head && head.err;
`else
    logic unused_head_err;
    assign timeout         = 1'b0;
    assign unused_head_err = head.err;
    assign out_err         = 1'b0;
`endif

    // Terminator needs no space check: an unfinished frame leaves its tail
    // slots reserved.
    always_comb begin
        push     = (state == PAYLOAD) && (io_input_trigger || timeout);
        wr_entry = '{data: 8'h00, chan: chan, last: 1'b1, err: 1'b1};
        if (io_input_trigger)
            wr_entry = '{data: io_input_value, chan: chan,
                         last: (remaining == 7'd1), err: 1'b0};
    end

    io_input_router_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    assign has_head = (count != '0);

    always_comb begin
        out_valid = '0;
        for (int c = 0; c < CHANNELS; c++)
            out_valid[c] = has_head && (head.chan == 2'(c));
    end

    // Only the head's channel can be valid, so a blocked head stalls all.
    assign pop      = |(out_valid & out_ready);
    assign out_data = has_head ? head.data : 8'h00;
    assign out_last = has_head && head.last;

    // Clear first, then add, so a coincident drop leaves a count of 1.
    assign dc_base = clear_overflow ? 8'd0 : drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HEADER;
            chan       <= '0;
            remaining  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop_evt || timeout) overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;

            if (drop_evt && dc_base != 8'hFF) drop_count <= dc_base + 8'd1;
            else                              drop_count <= dc_base;

            case (state)
                HEADER: begin
                    if (io_input_trigger) begin
                        remaining <= hdr_len;
                        if (admit) begin
                            chan  <= io_input_value[HDR_CHAN_HI:HDR_CHAN_LO];
                            state <= PAYLOAD;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                end
                PAYLOAD, DISCARD: begin
                    if (io_input_trigger) begin
                        remaining <= remaining - 7'd1;
                        if (remaining == 7'd1) state <= HEADER;
                    end else if (timeout) begin
                        state <= HEADER;
                    end
                end
                default: state <= HEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_io_input_router.sv
// tb_io_input_router: directed self-checking bench for io_input_router.
module tb_io_input_router;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] val = 8'h00;
    logic [3:0] ready = 4'h0;
    logic       clr = 1'b0;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_err;
    logic       overflow;
    logic [7:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_input_router #(
        .CH_BITS        (2),
        .FIFO_DEPTH     (64),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .io_input_trigger (trig),
        .io_input_value   (val),
        .out_valid        (out_valid),
        .out_ready        (ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_err          (out_err),
        .overflow         (overflow),
        .drop_count       (drop_count),
        .clear_overflow   (clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the byte taken.
    task automatic strobe(input logic [7:0] b);
        trig = 1'b1;
        val  = b;
        @(negedge clk);
        trig = 1'b0;
    endtask

    logic [7:0] exp_d [5];
    logic [3:0] exp_v [5];
    logic       exp_l [5];

    initial begin
        repeat (2) @(negedge clk);
        check("rst valid", out_valid, 4'h0);
        check("rst data", out_data, 8'h00);
        check("rst last", out_last, 1'b0);
        check("rst err", out_err, 1'b0);
        check("rst ovf", overflow, 1'b0);
        check("rst dc", drop_count, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 3-byte frame on channel 1, consumers always ready
        ready = 4'hF;
        strobe(8'h42);
        check("t1 hdr invisible", out_valid, 4'h0);
        strobe(8'h11);
        check("t1 v0", out_valid, 4'b0010);
        check("t1 d0", out_data, 8'h11);
        check("t1 l0", out_last, 1'b0);
        strobe(8'h22);
        check("t1 d1", out_data, 8'h22);
        check("t1 l1", out_last, 1'b0);
        strobe(8'h33);
        check("t1 v2", out_valid, 4'b0010);
        check("t1 d2", out_data, 8'h33);
        check("t1 l2", out_last, 1'b1);
        check("t1 ovf", overflow, 1'b0);
        @(negedge clk);
        check("t1 empty", out_valid, 4'h0);

        // Full FIFO: drops, clear coincident with drop, saturation
        ready = 4'h0;
        strobe(8'h3F);
        for (int i = 0; i < 64; i++) strobe(8'(i + 1));
        strobe(8'h80);
        check("t2 ovf", overflow, 1'b1);
        check("t2 dc hdr", drop_count, 8'd1);
        strobe(8'h77);
        check("t2 dc", drop_count, 8'd2);
        check("t2 head v", out_valid, 4'b0001);
        check("t2 head d", out_data, 8'h01);
        clr = 1'b1;
        strobe(8'h80);
        clr = 1'b0;
        check("t2 clr+drop ovf", overflow, 1'b1);
        check("t2 clr+drop dc", drop_count, 8'd1);
        strobe(8'h77);
        check("t2 dc2", drop_count, 8'd2);
        repeat (4) begin
            strobe(8'h3F);
            repeat (64) strobe(8'h00);
        end
        check("t2 dc sat", drop_count, 8'd255);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t2 clr ovf", overflow, 1'b0);
        check("t2 clr dc", drop_count, 8'd0);
        ready = 4'b0001;
        for (int i = 0; i < 64; i++) begin
            check("t2 drain d", out_data, 8'(i + 1));
            check("t2 drain l", out_last, (i == 63));
            @(negedge clk);
        end
        check("t2 drained", out_valid, 4'h0);
        ready = 4'h0;
        strobe(8'h80);
        strobe(8'h5A);
        check("t2 ch2 v", out_valid, 4'b0100);
        check("t2 ch2 d", out_data, 8'h5A);
        check("t2 ch2 l", out_last, 1'b1);
        ready = 4'b0100;
        @(negedge clk);
        check("t2 ch2 popped", out_valid, 4'h0);

        // In-order delivery with a blocked head
        ready = 4'h0;
        strobe(8'h41); strobe(8'hA1); strobe(8'hA2);
        strobe(8'hC1); strobe(8'hB1); strobe(8'hB2);
        strobe(8'h40); strobe(8'hA3);
        ready = 4'b1000;
        repeat (3) @(negedge clk);
        check("t3 blocked v", out_valid, 4'b0010);
        check("t3 blocked d", out_data, 8'hA1);
        exp_d = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hA3};
        exp_v = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010};
        ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("t3 order v", out_valid, exp_v[i]);
            check("t3 order d", out_data, exp_d[i]);
            @(negedge clk);
        end
        check("t3 empty", out_valid, 4'h0);

        // Push and pop on the same edge with 5 entries buffered
        ready = 4'h0;
        strobe(8'h04);
        for (int i = 1; i <= 5; i++) strobe(8'(i));
        strobe(8'h00);
        trig  = 1'b1;
        val   = 8'h66;
        ready = 4'b0001;
        @(negedge clk);
        trig  = 1'b0;
        ready = 4'h0;
        check("t4 head after pp", out_data, 8'h02);
        exp_d = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h66};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ready = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            check("t4 drain d", out_data, exp_d[i]);
            check("t4 drain l", out_last, exp_l[i]);
            @(negedge clk);
        end
        check("t4 count5", out_valid, 4'h0);
        ready = 4'h0;

`ifdef IO_INPUT_ROUTER_TIMEOUT_EN
        // Stalled frame terminated by the inter-byte timeout
        strobe(8'h03);
        strobe(8'hA1);
        strobe(8'hA2);
        check("t5 ovf pre", overflow, 1'b0);
        repeat (30) @(negedge clk);
        check("t5 ovf", overflow, 1'b1);
        ready = 4'b0001;
        check("t5 d0", out_data, 8'hA1);
        check("t5 e0", out_err, 1'b0);
        @(negedge clk);
        check("t5 d1", out_data, 8'hA2);
        @(negedge clk);
        check("t5 term v", out_valid, 4'b0001);
        check("t5 term d", out_data, 8'h00);
        check("t5 term l", out_last, 1'b1);
        check("t5 term e", out_err, 1'b1);
        @(negedge clk);
        ready = 4'h0;
        strobe(8'h40);
        strobe(8'h77);
        check("t5 hdr v", out_valid, 4'b0010);
        check("t5 hdr d", out_data, 8'h77);
        ready = 4'b0010;
        clr   = 1'b1;
        @(negedge clk);
        ready = 4'h0;
        clr   = 1'b0;
`endif

        // Asynchronous reset mid-frame
        strobe(8'h05);
        strobe(8'h01); strobe(8'h02); strobe(8'h03);
        check("t6 pre v", out_valid, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async v", out_valid, 4'h0);
        check("t6 async d", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        strobe(8'h80);
        strobe(8'h99);
        check("t6 hdr v", out_valid, 4'b0100);
        check("t6 hdr d", out_data, 8'h99);
        check("t6 hdr l", out_last, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_input_router.md
# io_input_router

Packet router between the UART receive byte stream (`io_input_trigger` / `io_input_value`) and up to four on-chip consumers. Parses a one-byte header per frame, admits the frame only if the whole payload fits in the internal FIFO, and delivers payload bytes to the addressed channel over a valid/ready handshake. It is the sole owner of the receive controller's output; consumers never see raw UART bytes.

## Interface
- `CH_BITS`, 2: channel field width; `CHANNELS = 1 << CH_BITS`, fixed 4 with the current header format.
- `FIFO_DEPTH`, 64: payload FIFO entries; power of two, ≥ 64.
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout in clocks, used only with the timeout feature.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_input_trigger` in 1: one-cycle strobe, byte valid.
- `io_input_value` in 8: received byte, sampled when trigger=1.
- `out_valid` out CHANNELS: one-hot, head entry available for that channel.
- `out_ready` in CHANNELS: consumer accepts.
- `out_data` out 8: head payload byte.
- `out_last` out 1: head byte ends its frame.
- `out_err` out 1: head entry is a timeout terminator.
- `overflow` out 1: sticky, set when any frame is discarded.
- `drop_count` out 8: discarded bytes, saturates at 255.
- `clear_overflow` in 1: clears `overflow` and `drop_count`.

## Operation
- Header byte: `[7:6]` channel, `[5:0]` length−1, so payload is 1..64 bytes. Headers are never stored.
- Parser states (package enum):
  - HEADER: on trigger, compute len = `[5:0]`+1 and free = FIFO_DEPTH − count, using the count before this cycle's pop.
    - If free ≥ len: latch chan and remaining = len, go to PAYLOAD.
    - Else: set `overflow`, add 1 to `drop_count`, go to DISCARD with remaining = len.
  - PAYLOAD: on each trigger, push {data, chan, last = (remaining==1), err=0} and decrement remaining. After the last byte, go to HEADER.
  - DISCARD: on each trigger, drop the byte, add 1 to `drop_count`, decrement remaining. At 0, go to HEADER.
- Admission guarantees a complete frame always fits: the FIFO is never full on a PAYLOAD push, because free space only grows while a frame is in progress.
- Output side (first-word-fall-through):
  - When count > 0, `out_valid[head.chan]` = 1 and all other bits are 0.
  - Pop occurs when `out_valid & out_ready` is non-zero.
  - A blocked channel stalls all channels (strict in-order delivery).
- Push and pop in the same cycle both take effect; count is unchanged.
- `clear_overflow` in the same cycle as a new drop: the set wins, and `drop_count` becomes 1 (clear first, then add).
- Reset (async, anytime):
  - FIFO empties; state = HEADER.
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_err` = 0, `overflow` = 0, `drop_count` = 0.
  - A frame in progress is lost with no terminator.

## Timing
- Byte strobed at cycle N appears on `out_*` at N+1 if the FIFO was empty.
- Pop at edge N exposes the next entry at N+1; sustained throughput is 1 byte/clock.
- A header costs no output cycle; the admission decision is registered on the trigger edge.
- A trigger arriving while in HEADER is always treated as a header, including immediately after a frame's last byte.
- `drop_count` arithmetic is 8-bit with saturation: 255 + 1 = 255.
- remaining is a 7-bit counter (holds 64).

## Configuration
- `IO_INPUT_ROUTER_TIMEOUT_EN` defined:
  - In PAYLOAD or DISCARD, an idle counter counts clocks since the last trigger.
  - On reaching TIMEOUT_CYCLES, the parser returns to HEADER and sets `overflow`.
  - If in PAYLOAD, it pushes one terminator {data=0x00, chan, last=1, err=1}. This always fits, because at least one reserved slot remains.
  - If a trigger arrives on the same edge as the timeout, the trigger wins and the counter reloads.
- Not defined:
  - No counter is built; `out_err` is tied to 0.
  - The parser waits indefinitely for the remaining bytes.

## Structure
- Package `io_input_router_pkg`:
  - Parser state enum (HEADER, PAYLOAD, DISCARD).
  - Packed FIFO entry struct {data[7:0], chan[1:0], last, err}.
  - Header field position constants.
- One sub-module, `io_input_router_fifo`: a parameterised synchronous FWFT FIFO with `count` output and async active-low reset.
- Parser, admission logic, and counters stay in the top module.

## Test plan
- Header 0x42 then bytes 0x11,0x22,0x33 with `out_ready`=4'b1111 -> `out_valid`=4'b0010 three times, data 11/22/33, `out_last` only on 0x33, `overflow`=0.
- Fill FIFO with a 64-byte frame (0x3F header) on channel 0 with `out_ready`=0, then header 0x80 plus 1 byte -> second frame dropped, `overflow`=1, `drop_count`=2; after draining, header 0x80 + 0x5A is delivered on channel 2.
- Interleaved frames on channels 1 and 3 with channel 1 not ready -> channel 3 bytes do not pass the blocked head; delivery order is exactly arrival order once ready.
- Push and pop in the same cycle with FIFO count 5 -> count stays 5; `clear_overflow` coincident with a drop -> `overflow`=1, `drop_count`=1.
- With `IO_INPUT_ROUTER_TIMEOUT_EN`: header 0x03 (4 bytes), send 2 bytes, wait TIMEOUT_CYCLES -> third entry is data 0x00 with `out_last`=1, `out_err`=1; next byte is parsed as a header.
- Assert `rst_n`=0 mid-frame with 3 bytes buffered -> `out_valid`=0 immediately (async); after release, next byte is parsed as a header.
